ubss_stream_ctrl: RTL and testbench

- Parametrised sequencer that drives one UB + skewer + systolic-array datapath through a complete K-deep matrix tile.
- Accepts a tile descriptor through a valid/ready handshake: base addresses, strides, K length, precision, accumulate/drain flags.
- Issues strided UB read addresses with first/last markers, generates acc_clear, compute_enable, skewer enable and drain_enable, waits for array completion, then pulses done.
- Sits between the host command path and the datapath wrapper, replacing hand-driven address/control ports.

---
 rtl/ubss_stream_ctrl_pkg.sv | 47 ++++
 rtl/ubss_stream_ctrl_if.sv | 53 +++++
 rtl/ubss_stream_ctrl_stride_addr_gen.sv | 29 ++
 rtl/ubss_stream_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_ubss_stream_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ubss_stream_ctrl_pkg.sv
// Shared types for the UB/skewer/systolic-array stream controller.
// ARRAY_SIZE and ADDR_WIDTH come from the project defines; local fallbacks apply when they are absent.
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

package ubss_ctrl_pkg;

  localparam int UBSS_N        = `ARRAY_SIZE;
  localparam int UBSS_ADDR_W   = `ADDR_WIDTH;
  localparam int UBSS_K_W      = 16;
  localparam int UBSS_STRIDE_W = 8;

  localparam logic [UBSS_STRIDE_W-1:0] DEFAULT_IN_STRIDE = UBSS_STRIDE_W'(1);
  localparam logic [UBSS_STRIDE_W-1:0] DEFAULT_W_STRIDE  = UBSS_STRIDE_W'(1);

  typedef enum logic [1:0] {
    PREC_INT8 = 2'd0,
    PREC_INT4 = 2'd1,
    PREC_FP8  = 2'd2,
    PREC_BF16 = 2'd3
  } precision_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } ubss_ctrl_state_t;

  typedef struct packed {
    logic [UBSS_ADDR_W-1:0]   in_base;
    logic [UBSS_ADDR_W-1:0]   w_base;
    logic [UBSS_STRIDE_W-1:0] in_stride;
    logic [UBSS_STRIDE_W-1:0] w_stride;
    logic [UBSS_K_W-1:0]      k_len;
    precision_mode_t          precision;
    logic                     accumulate;
    logic                     drain;
  } ubss_tile_cfg_t;

endpackage

// File: rtl/ubss_stream_ctrl_if.sv
// Descriptor handshake plus UB/array control bundle between host path, controller and datapath.
interface ubss_stream_ctrl_if #(
  parameter int ADDR_WIDTH   = ubss_ctrl_pkg::UBSS_ADDR_W,
  parameter int K_WIDTH      = ubss_ctrl_pkg::UBSS_K_W,
  parameter int STRIDE_WIDTH = ubss_ctrl_pkg::UBSS_STRIDE_W
);
  import ubss_ctrl_pkg::*;

  logic                    start_valid;
  logic                    start_ready;
  logic [ADDR_WIDTH-1:0]   cfg_in_base;
  logic [ADDR_WIDTH-1:0]   cfg_w_base;
  logic [STRIDE_WIDTH-1:0] cfg_in_stride;
  logic [STRIDE_WIDTH-1:0] cfg_w_stride;
  logic [K_WIDTH-1:0]      cfg_k_len;
  precision_mode_t         cfg_precision;
  logic                    cfg_accumulate;
  logic                    cfg_drain;
  logic                    stall;
  logic                    sa_computation_done;

  logic                    en;
  logic [ADDR_WIDTH-1:0]   input_addr;
  logic                    input_first_in;
  logic                    input_last_in;
  logic [ADDR_WIDTH-1:0]   weight_addr;
  logic                    weight_first_in;
  logic                    weight_last_in;
  precision_mode_t         precision_mode;
  logic                    compute_enable;
  logic                    acc_clear;
  logic                    drain_enable;
  logic                    busy;
  logic                    done;
  logic                    err;

  modport slave (
    input  start_valid, cfg_in_base, cfg_w_base, cfg_in_stride, cfg_w_stride,
           cfg_k_len, cfg_precision, cfg_accumulate, cfg_drain, stall, sa_computation_done,
    output start_ready, en, input_addr, input_first_in, input_last_in, weight_addr,
           weight_first_in, weight_last_in, precision_mode, compute_enable, acc_clear,
           drain_enable, busy, done, err
  );

  modport master (
    output start_valid, cfg_in_base, cfg_w_base, cfg_in_stride, cfg_w_stride,
           cfg_k_len, cfg_precision, cfg_accumulate, cfg_drain, stall, sa_computation_done,
    input  start_ready, en, input_addr, input_first_in, input_last_in, weight_addr,
           weight_first_in, weight_last_in, precision_mode, compute_enable, acc_clear,
           drain_enable, busy, done, err
  );

endinterface

// File: rtl/ubss_stream_ctrl_stride_addr_gen.sv
// Strided UB address generator: load a base, add the stride on each advance strobe, wrap modulo 2^ADDR_WIDTH.
module stride_addr_gen #(
  parameter int ADDR_WIDTH   = 8,
  parameter int STRIDE_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    load,
  input  logic                    advance,
  input  logic [ADDR_WIDTH-1:0]   base,
  input  logic [STRIDE_WIDTH-1:0] stride,
  output logic [ADDR_WIDTH-1:0]   addr
);

  // Clear wins over load so the address bus returns to zero between tiles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (clear) begin
      addr <= '0;
    end else if (load) begin
      addr <= base;
    end else if (advance) begin
      addr <= addr + ADDR_WIDTH'(stride);
    end
  end

endmodule

// File: rtl/ubss_stream_ctrl.sv
// Tile sequencer for one UB + skewer + systolic-array datapath: CLEAR, STREAM, FLUSH, DRAIN, DONE.
// Define UBSS_CTRL_TIMEOUT_EN to add a FLUSH watchdog that ends the tile with err after TIMEOUT_CYCLES.
module ubss_stream_ctrl
  import ubss_ctrl_pkg::*;
#(
  parameter int N            = UBSS_N,
  parameter int ADDR_WIDTH   = UBSS_ADDR_W,
  parameter int K_WIDTH      = UBSS_K_W,
  parameter int STRIDE_WIDTH = UBSS_STRIDE_W,
`ifdef UBSS_CTRL_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 4096,
`endif
  parameter int DRAIN_CYCLES = N
) (
  input  logic               clk,
  input  logic               rst_n,
  ubss_stream_ctrl_if.slave  bus
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
`ifdef UBSS_CTRL_TIMEOUT_EN
  localparam int TOUT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TOUT_W-1:0]  tout_cnt;
`endif

  ubss_ctrl_state_t   state;
  ubss_tile_cfg_t     cfg_q;
  ubss_tile_cfg_t     cfg_in;
  logic [K_WIDTH-1:0] idx;
  logic [K_WIDTH-1:0] k_last;
  logic [DRAIN_W-1:0] drain_cnt;

  logic start_ready_q, busy_q, stream_q, first_q, last_q, drain_q, done_q, err_q;
  logic accept, gen_load, gen_advance, gen_clear;
  logic [ADDR_WIDTH-1:0] in_load_base, w_load_base;

  always_comb begin
    cfg_in            = '0;
    cfg_in.in_base    = UBSS_ADDR_W'(bus.cfg_in_base);
    cfg_in.w_base     = UBSS_ADDR_W'(bus.cfg_w_base);
    cfg_in.in_stride  = UBSS_STRIDE_W'(bus.cfg_in_stride);
    cfg_in.w_stride   = UBSS_STRIDE_W'(bus.cfg_w_stride);
    cfg_in.k_len      = UBSS_K_W'(bus.cfg_k_len);
    cfg_in.precision  = bus.cfg_precision;
    cfg_in.accumulate = bus.cfg_accumulate;
    cfg_in.drain      = bus.cfg_drain;
  end

  assign accept = bus.start_valid & start_ready_q;
  assign k_last = K_WIDTH'(cfg_q.k_len) - K_WIDTH'(1);

  // The generators are loaded on the cycle before the first row: from the live inputs when
  // accumulate skips CLEAR, otherwise from the latched descriptor while in CLEAR.
  assign gen_load    = (state == ST_CLEAR) |
                       (accept & bus.cfg_accumulate & (bus.cfg_k_len != '0));
  assign gen_advance = (state == ST_STREAM) & ~bus.stall & ~last_q;
  assign gen_clear   = (state == ST_DONE);
  assign in_load_base = (state == ST_IDLE) ? ADDR_WIDTH'(bus.cfg_in_base) : ADDR_WIDTH'(cfg_q.in_base);
  assign w_load_base  = (state == ST_IDLE) ? ADDR_WIDTH'(bus.cfg_w_base)  : ADDR_WIDTH'(cfg_q.w_base);

  stride_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .STRIDE_WIDTH(STRIDE_WIDTH)) u_in_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (gen_clear),
    .load    (gen_load),
    .advance (gen_advance),
    .base    (in_load_base),
    .stride  (STRIDE_WIDTH'(cfg_q.in_stride)),
    .addr    (bus.input_addr)
  );

  stride_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .STRIDE_WIDTH(STRIDE_WIDTH)) u_w_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (gen_clear),
    .load    (gen_load),
    .advance (gen_advance),
    .base    (w_load_base),
    .stride  (STRIDE_WIDTH'(cfg_q.w_stride)),
    .addr    (bus.weight_addr)
  );

  // Sequencer: output flags are registered on each transition; stall only gates them below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cfg_q         <= '0;
      idx           <= '0;
      drain_cnt     <= '0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      stream_q      <= 1'b0;
      first_q       <= 1'b0;
      last_q        <= 1'b0;
      drain_q       <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
`ifdef UBSS_CTRL_TIMEOUT_EN
      tout_cnt      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cfg_q         <= cfg_in;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            idx           <= '0;
            if (bus.cfg_k_len == '0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (bus.cfg_accumulate) begin
              state    <= ST_STREAM;
              stream_q <= 1'b1;
              first_q  <= 1'b1;
              last_q   <= (bus.cfg_k_len == K_WIDTH'(1));
            end else begin
              state <= ST_CLEAR;
            end
          end
        end
        ST_CLEAR: begin
          state    <= ST_STREAM;
          stream_q <= 1'b1;
          first_q  <= 1'b1;
          last_q   <= (k_last == '0);
        end
        ST_STREAM: begin
          if (!bus.stall) begin
            first_q <= 1'b0;
            if (last_q) begin
              state  <= ST_FLUSH;
              last_q <= 1'b0;
`ifdef UBSS_CTRL_TIMEOUT_EN
              tout_cnt <= '0;
`endif
            end else begin
              idx    <= idx + K_WIDTH'(1);
              last_q <= ((idx + K_WIDTH'(1)) == k_last);
            end
          end
        end
        ST_FLUSH: begin
          if (bus.sa_computation_done) begin
            stream_q <= 1'b0;
            if (cfg_q.drain) begin
              state     <= ST_DRAIN;
              drain_q   <= 1'b1;
              drain_cnt <= '0;
            end else begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end
`ifdef UBSS_CTRL_TIMEOUT_EN
          else if (!bus.stall) begin
            if (tout_cnt == TOUT_W'(TIMEOUT_CYCLES - 1)) begin
              stream_q <= 1'b0;
              state    <= ST_DONE;
              done_q   <= 1'b1;
              err_q    <= 1'b1;
            end else begin
              tout_cnt <= tout_cnt + TOUT_W'(1);
            end
          end
`endif
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
            drain_q <= 1'b0;
            state   <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        ST_DONE: begin
          done_q        <= 1'b0;
          err_q         <= 1'b0;
          busy_q        <= 1'b0;
          start_ready_q <= 1'b1;
          cfg_q         <= '0;
          idx           <= '0;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.start_ready     = start_ready_q;
  assign bus.busy            = busy_q;
  assign bus.en              = stream_q & ~bus.stall;
  assign bus.compute_enable  = stream_q & ~bus.stall;
  assign bus.input_first_in  = first_q & ~bus.stall;
  assign bus.input_last_in   = last_q & ~bus.stall;
  assign bus.weight_first_in = first_q & ~bus.stall;
  assign bus.weight_last_in  = last_q & ~bus.stall;
  assign bus.acc_clear       = (state == ST_CLEAR) & ~cfg_q.accumulate;
  assign bus.drain_enable    = drain_q;
  assign bus.done            = done_q;
  assign bus.err             = err_q;
  assign bus.precision_mode  = cfg_q.precision;

endmodule

// File: tb/tb_ubss_stream_ctrl.sv
// Self-checking bench for ubss_stream_ctrl: directed and random tiles against a per-tile schedule model.
// Build with UBSS_CTRL_TIMEOUT_EN to also cover the FLUSH watchdog (TIMEOUT_CYCLES=16).
module tb_ubss_stream_ctrl;
  import ubss_ctrl_pkg::*;

  localparam int AW   = UBSS_ADDR_W;
  localparam int DRN  = UBSS_N;
  localparam int MAXC = 160;
  localparam int TOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ubss_stream_ctrl_if bus();

`ifdef UBSS_CTRL_TIMEOUT_EN
  ubss_stream_ctrl #(.TIMEOUT_CYCLES(TOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
  ubss_stream_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [AW-1:0]   dInBase, dWBase;
  logic [7:0]      dInStr, dWStr;
  logic [15:0]     dK;
  precision_mode_t dPrec;
  logic            dAcc, dDrain;
  int              saDelay;
  bit              spurOn;

  logic [11:0]   expCtrl [MAXC];
  logic [AW-1:0] expIn   [MAXC];
  logic [AW-1:0] expW    [MAXC];
  bit            addrValid [MAXC];
  bit            stallPat  [MAXC];
  int            saCycle, spurCycle, endCycle;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, required 0x%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [11:0] packCtrl(logic rdy, logic bsy, logic e, logic f, logic l,
                                           logic clr, logic drn, logic dn, logic er);
    return {rdy, bsy, e, e, f, l, f, l, clr, drn, dn, er};
  endfunction

  function automatic logic [11:0] ctrlObs();
    return {bus.start_ready, bus.busy, bus.en, bus.compute_enable,
            bus.input_first_in, bus.input_last_in, bus.weight_first_in, bus.weight_last_in,
            bus.acc_clear, bus.drain_enable, bus.done, bus.err};
  endfunction

  // Expected per-cycle behaviour, indexed by cycles after the accept edge.
  task automatic buildSchedule();
    int c, row, lastRow, firstRow, cnt;
    bit fin, timedOut;
    for (int i = 0; i < MAXC; i++) begin
      expCtrl[i]   = packCtrl(1, 0, 0, 0, 0, 0, 0, 0, 0);
      addrValid[i] = 0;
      expIn[i]     = '0;
      expW[i]      = '0;
    end
    saCycle   = -1;
    spurCycle = -1;
    if (dK == 0) begin
      expCtrl[1] = packCtrl(0, 1, 0, 0, 0, 0, 0, 1, 1);
      endCycle   = 2;
      return;
    end
    c = 1;
    if (!dAcc) begin
      expCtrl[1] = packCtrl(0, 1, 0, 0, 0, 1, 0, 0, 0);
      c = 2;
    end
    firstRow = c;
    row = 0;
    while (row < int'(dK)) begin
      expIn[c]     = AW'(int'(dInBase) + row * int'(dInStr));
      expW[c]      = AW'(int'(dWBase) + row * int'(dWStr));
      addrValid[c] = 1;
      if (stallPat[c]) expCtrl[c] = packCtrl(0, 1, 0, 0, 0, 0, 0, 0, 0);
      else begin
        expCtrl[c] = packCtrl(0, 1, 1, row == 0, row == int'(dK) - 1, 0, 0, 0, 0);
        row++;
      end
      c++;
    end
    lastRow = c - 1;
    if (spurOn) spurCycle = $urandom_range(lastRow, firstRow);
    if (saDelay >= 0) saCycle = lastRow + 1 + saDelay;
    cnt = 0;
    fin = 0;
    timedOut = 0;
    while (!fin) begin
      expIn[c]     = expIn[lastRow];
      expW[c]      = expW[lastRow];
      addrValid[c] = 1;
      expCtrl[c]   = packCtrl(0, 1, !stallPat[c], 0, 0, 0, 0, 0, 0);
      if (c == saCycle) fin = 1;
`ifdef UBSS_CTRL_TIMEOUT_EN
      else if (!stallPat[c]) begin
        cnt++;
        if (cnt == TOUT) begin fin = 1; timedOut = 1; end
      end
`endif
      c++;
    end
    if (!timedOut && dDrain) begin
      for (int j = 0; j < DRN; j++) begin
        expCtrl[c] = packCtrl(0, 1, 0, 0, 0, 0, 1, 0, 0);
        c++;
      end
    end
    expCtrl[c] = packCtrl(0, 1, 0, 0, 0, 0, 0, 1, timedOut);
    endCycle = c + 1;
  endtask

  task automatic driveDescriptor();
    bus.cfg_in_base    = dInBase;
    bus.cfg_w_base     = dWBase;
    bus.cfg_in_stride  = dInStr;
    bus.cfg_w_stride   = dWStr;
    bus.cfg_k_len      = dK;
    bus.cfg_precision  = dPrec;
    bus.cfg_accumulate = dAcc;
    bus.cfg_drain      = dDrain;
  endtask

  task automatic scrambleDescriptor();
    bus.cfg_in_base    = AW'($urandom);
    bus.cfg_w_base     = AW'($urandom);
    bus.cfg_in_stride  = 8'($urandom);
    bus.cfg_w_stride   = 8'($urandom);
    bus.cfg_k_len      = 16'($urandom_range(0, 9));
    bus.cfg_precision  = precision_mode_t'($urandom_range(0, 3));
    bus.cfg_accumulate = 1'($urandom);
    bus.cfg_drain      = 1'($urandom);
  endtask

  task automatic clearStalls();
    for (int i = 0; i < MAXC; i++) stallPat[i] = 0;
  endtask

  // Runs one tile; entered and left 1 time unit after a rising edge with the DUT idle.
  task automatic applyStimulus();
    buildSchedule();
    driveDescriptor();
    bus.start_valid = 1'b1;
    bus.stall = 1'b0;
    bus.sa_computation_done = 1'b0;
    @(negedge clk);
    checkOutput("idle_ready", 64'(ctrlObs()), 64'(packCtrl(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    @(posedge clk); #1;
    for (int c = 1; c <= endCycle; c++) begin
      scrambleDescriptor();
      bus.start_valid = (c < endCycle) ? 1'($urandom) : 1'b0;
      bus.stall = stallPat[c];
      bus.sa_computation_done = (c == saCycle) || (c == spurCycle);
      @(negedge clk);
      checkOutput("ctrl", 64'(ctrlObs()), 64'(expCtrl[c]));
      if (addrValid[c]) begin
        checkOutput("input_addr", 64'(bus.input_addr), 64'(expIn[c]));
        checkOutput("weight_addr", 64'(bus.weight_addr), 64'(expW[c]));
      end
      checkOutput("precision", 64'(bus.precision_mode), (c < endCycle) ? 64'(dPrec) : 64'(0));
      @(posedge clk); #1;
    end
    bus.start_valid = 1'b0;
    bus.stall = 1'b0;
    bus.sa_computation_done = 1'b0;
  endtask

  task automatic setTile(input logic [AW-1:0] ib, input logic [AW-1:0] wb, input logic [7:0] is,
                         input logic [7:0] ws, input logic [15:0] k, input logic acc,
                         input logic drn, input int dly);
    dInBase = ib; dWBase = wb; dInStr = is; dWStr = ws; dK = k;
    dAcc = acc; dDrain = drn; saDelay = dly;
    dPrec = precision_mode_t'($urandom_range(0, 3));
    spurOn = 0;
    clearStalls();
  endtask

  task automatic resetMidStream();
    setTile(AW'(8'h20), AW'(8'h40), 8'd2, 8'd3, 16'd6, 1'b0, 1'b1, 0);
    driveDescriptor();
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    checkOutput("pre_reset_en", 64'(bus.en), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_ctrl", 64'(ctrlObs()), 64'(packCtrl(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    checkOutput("async_reset_addr", {32'(bus.input_addr), 32'(bus.weight_addr)}, 64'(0));
    checkOutput("async_reset_prec", 64'(bus.precision_mode), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.stall = 1'b0;
    bus.sa_computation_done = 1'b0;
    scrambleDescriptor();
    clearStalls();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ctrl", 64'(ctrlObs()), 64'(packCtrl(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    checkOutput("reset_addr", {32'(bus.input_addr), 32'(bus.weight_addr)}, 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] basic tile");
    setTile(AW'(8'h10), AW'(8'h80), DEFAULT_IN_STRIDE, DEFAULT_W_STRIDE, 16'd4, 1'b0, 1'b1, 5);
    applyStimulus();

    $display("[TB] accumulate single row");
    setTile(AW'(8'h30), AW'(8'h50), 8'd4, 8'd4, 16'd1, 1'b1, 1'b0, 2);
    applyStimulus();

    $display("[TB] stall after first row");
    setTile(AW'(8'h00), AW'(8'h60), 8'd1, 8'd2, 16'd3, 1'b0, 1'b1, 1);
    stallPat[3] = 1;
    stallPat[4] = 1;
    applyStimulus();

    $display("[TB] address wrap");
    setTile(AW'(8'hFE), AW'(8'hFD), 8'd1, 8'd3, 16'd4, 1'b0, 1'b0, 0);
    applyStimulus();

    $display("[TB] zero length");
    setTile(AW'(8'h11), AW'(8'h22), 8'd1, 8'd1, 16'd0, 1'b0, 1'b1, 0);
    applyStimulus();

    $display("[TB] reset mid-stream");
    resetMidStream();
    setTile(AW'(8'h05), AW'(8'hA0), 8'd7, 8'd9, 16'd2, 1'b1, 1'b1, 3);
    applyStimulus();

`ifdef UBSS_CTRL_TIMEOUT_EN
    $display("[TB] flush timeout");
    setTile(AW'(8'h40), AW'(8'h41), 8'd1, 8'd1, 16'd3, 1'b0, 1'b1, -1);
    applyStimulus();
`endif

    $display("[TB] random tiles");
    for (int t = 0; t < 40; t++) begin
      setTile(AW'($urandom), AW'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 8)),
              1'($urandom), 1'($urandom), $urandom_range(0, 5));
      spurOn = ($urandom_range(0, 2) == 0);
      for (int c = 1; c < 40; c++) stallPat[c] = ($urandom_range(0, 3) == 0);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
